// File: rtl/if_fetch_pkg.sv
// rtl/if_fetch_pkg.sv - shared types and constants for the instruction-fetch stage
package if_fetch_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_DROP = 2'd3
  } fetch_state_e;

  localparam logic [63:0] RESET_PC_DEFAULT = 64'h8000_0000;

endpackage

// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - instruction-fetch stage: PC, one-outstanding imem fetch, output and skid entries
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter int              INST_LEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall_n,
  input  logic                redirect_valid,
  input  logic [XLEN-1:0]     redirect_pc,
  output logic                imem_req,
  output logic [XLEN-1:0]     imem_addr,
  input  logic                imem_gnt,
  input  logic                imem_rvalid,
  input  logic [INST_LEN-1:0] imem_rdata,
  output logic [XLEN-1:0]     pc_if_o,
  output logic [INST_LEN-1:0] instr_if_o,
  output logic                valid_if_o
);

  fetch_state_e        r_state;
  logic [XLEN-1:0]     r_pc;
  logic [XLEN-1:0]     r_pc_out;
  logic [INST_LEN-1:0] r_instr;
  logic                r_valid;
  logic [INST_LEN-1:0] r_skid;

  logic w_consume;
  logic w_room;

  assign w_consume = r_valid && stall_n;
  assign w_room    = !r_valid || w_consume;

  assign imem_req   = (r_state == S_REQ);
  assign imem_addr  = r_pc;
  assign pc_if_o    = r_pc_out;
  assign instr_if_o = r_instr;
  assign valid_if_o = r_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_REQ;
      r_pc     <= RESET_PC;
      r_pc_out <= '0;
      r_instr  <= '0;
      r_valid  <= 1'b0;
      r_skid   <= '0;
    end else if (redirect_valid) begin
      // A granted-but-unanswered fetch must be drained in DROP before refetching.
      r_pc    <= {redirect_pc[XLEN-1:2], 2'b00};
      r_valid <= 1'b0;
      r_instr <= '0;
      r_skid  <= '0;
      case (r_state)
        S_REQ:   r_state <= imem_gnt    ? S_DROP : S_REQ;
        S_WAIT:  r_state <= imem_rvalid ? S_REQ  : S_DROP;
        S_HOLD:  r_state <= S_REQ;
        S_DROP:  r_state <= imem_rvalid ? S_REQ  : S_DROP;
        default: r_state <= S_REQ;
      endcase
    end else begin
      if (w_consume) begin
        r_valid <= 1'b0;
        r_instr <= '0;
      end
      case (r_state)
        S_REQ: begin
          if (imem_gnt) r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            if (w_room) begin
              r_pc_out <= r_pc;
              r_instr  <= imem_rdata;
              r_valid  <= 1'b1;
              r_pc     <= r_pc + XLEN'(4);
              r_state  <= S_REQ;
            end else begin
              r_skid  <= imem_rdata;
              r_state <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (w_room) begin
            r_pc_out <= r_pc;
            r_instr  <= r_skid;
            r_valid  <= 1'b1;
            r_pc     <= r_pc + XLEN'(4);
            r_state  <= S_REQ;
          end
        end
        S_DROP: begin
          if (imem_rvalid) r_state <= S_REQ;
        end
        default: r_state <= S_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// tb/tb_if_fetch.sv - directed self-checking bench for if_fetch
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_n;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [63:0] pc_if_o;
  logic [31:0] instr_if_o;
  logic        valid_if_o;

  int vectors = 0;
  int miscompares = 0;

  if_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .stall_n        (stall_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .pc_if_o        (pc_if_o),
    .instr_if_o     (instr_if_o),
    .valid_if_o     (valid_if_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall_n = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    tick(); tick();
    rst = 1'b0;
    vectors++;
    if (valid_if_o !== 1'b0 || pc_if_o !== 64'h0 || instr_if_o !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: valid=%0b pc=%h instr=%h, want 0/0/0", valid_if_o, pc_if_o, instr_if_o);
    end
    tick();
    vectors++;
    if (imem_req !== 1'b1 || imem_addr !== 64'h8000_0000) begin
      miscompares++;
      $display("FAIL reset_req: req=%0b addr=%h, want 1/80000000", imem_req, imem_addr);
    end
  endtask

  task automatic test_stream();
    for (int i = 0; i < 3; i++) begin
      logic [63:0] a;
      logic [31:0] d;
      a = 64'h8000_0000 + 64'(4 * i);
      d = 32'h0000_0013 + 32'(i << 7);
      vectors++;
      if (imem_req !== 1'b1 || imem_addr !== a) begin
        miscompares++;
        $display("FAIL stream_req%0d: req=%0b addr=%h, want 1/%h", i, imem_req, imem_addr, a);
      end
      imem_gnt = 1'b1;
      tick();
      imem_gnt = 1'b0;
      vectors++;
      if (valid_if_o !== 1'b0 || imem_req !== 1'b0) begin
        miscompares++;
        $display("FAIL stream_gap%0d: valid=%0b req=%0b, want 0/0", i, valid_if_o, imem_req);
      end
      imem_rvalid = 1'b1; imem_rdata = d;
      tick();
      imem_rvalid = 1'b0;
      vectors++;
      if (valid_if_o !== 1'b1 || pc_if_o !== a || instr_if_o !== d) begin
        miscompares++;
        $display("FAIL stream_out%0d: valid=%0b pc=%h instr=%h, want 1/%h/%h", i, valid_if_o, pc_if_o, instr_if_o, a, d);
      end
    end
  endtask

  task automatic test_stall();
    // Entry 0x80000008 still valid; stall for 5 cycles while the next fetch lands.
    stall_n = 1'b0;
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'hCAFE_0001;
    tick();
    imem_rvalid = 1'b0;
    vectors++;
    if (imem_req !== 1'b0 || valid_if_o !== 1'b1 || pc_if_o !== 64'h8000_0008 || instr_if_o !== 32'h0000_0113) begin
      miscompares++;
      $display("FAIL stall_hold: req=%0b valid=%0b pc=%h instr=%h, want 0/1/80000008/00000113", imem_req, valid_if_o, pc_if_o, instr_if_o);
    end
    tick(); tick(); tick();
    vectors++;
    if (imem_req !== 1'b0 || instr_if_o !== 32'h0000_0113) begin
      miscompares++;
      $display("FAIL stall_still: req=%0b instr=%h, want 0/00000113", imem_req, instr_if_o);
    end
    stall_n = 1'b1;
    tick();
    vectors++;
    if (valid_if_o !== 1'b1 || pc_if_o !== 64'h8000_000C || instr_if_o !== 32'hCAFE_0001 ||
        imem_req !== 1'b1 || imem_addr !== 64'h8000_0010) begin
      miscompares++;
      $display("FAIL stall_skid: valid=%0b pc=%h instr=%h req=%0b addr=%h, want 1/8000000c/cafe0001/1/80000010",
               valid_if_o, pc_if_o, instr_if_o, imem_req, imem_addr);
    end
    tick();
    vectors++;
    if (valid_if_o !== 1'b0 || instr_if_o !== 32'h0) begin
      miscompares++;
      $display("FAIL stall_drain: valid=%0b instr=%h, want 0/0", valid_if_o, instr_if_o);
    end
  endtask

  task automatic test_redirect_drop();
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 64'h8000_1002;
    tick();
    redirect_valid = 1'b0;
    tick();
    vectors++;
    if (imem_req !== 1'b0 || valid_if_o !== 1'b0) begin
      miscompares++;
      $display("FAIL rdrop_wait: req=%0b valid=%0b, want 0/0", imem_req, valid_if_o);
    end
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_rvalid = 1'b0;
    vectors++;
    if (imem_req !== 1'b1 || imem_addr !== 64'h8000_1000 || valid_if_o !== 1'b0 || instr_if_o !== 32'h0) begin
      miscompares++;
      $display("FAIL rdrop_refetch: req=%0b addr=%h valid=%0b instr=%h, want 1/80001000/0/0", imem_req, imem_addr, valid_if_o, instr_if_o);
    end
  endtask

  task automatic test_redirect_wait_hold();
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 64'h8000_2000;
    imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_0000;
    tick();
    redirect_valid = 1'b0; imem_rvalid = 1'b0;
    vectors++;
    if (imem_req !== 1'b1 || imem_addr !== 64'h8000_2000 || valid_if_o !== 1'b0) begin
      miscompares++;
      $display("FAIL rwait: req=%0b addr=%h valid=%0b, want 1/80002000/0", imem_req, imem_addr, valid_if_o);
    end
    imem_gnt = 1'b1; tick(); imem_gnt = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'h1111_1111; tick(); imem_rvalid = 1'b0;
    stall_n = 1'b0;
    imem_gnt = 1'b1; tick(); imem_gnt = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'h2222_2222; tick(); imem_rvalid = 1'b0;
    vectors++;
    if (imem_req !== 1'b0 || valid_if_o !== 1'b1 || pc_if_o !== 64'h8000_2000 || instr_if_o !== 32'h1111_1111) begin
      miscompares++;
      $display("FAIL rhold_pre: req=%0b valid=%0b pc=%h instr=%h, want 0/1/80002000/11111111", imem_req, valid_if_o, pc_if_o, instr_if_o);
    end
    redirect_valid = 1'b1; redirect_pc = 64'h8000_3000;
    tick();
    redirect_valid = 1'b0;
    stall_n = 1'b1;
    vectors++;
    if (imem_req !== 1'b1 || imem_addr !== 64'h8000_3000 || valid_if_o !== 1'b0 || instr_if_o !== 32'h0) begin
      miscompares++;
      $display("FAIL rhold: req=%0b addr=%h valid=%0b instr=%h, want 1/80003000/0/0", imem_req, imem_addr, valid_if_o, instr_if_o);
    end
  endtask

  task automatic test_redirect_req_gnt();
    redirect_valid = 1'b1; redirect_pc = 64'h8000_4000; imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    vectors++;
    if (imem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL rgnt_drop: req=%0b, want 0", imem_req);
    end
    redirect_pc = 64'h8000_500B;
    tick();
    redirect_valid = 1'b0;
    vectors++;
    if (imem_req !== 1'b0 || imem_addr !== 64'h8000_5008) begin
      miscompares++;
      $display("FAIL rgnt_second: req=%0b addr=%h, want 0/80005008", imem_req, imem_addr);
    end
    imem_rvalid = 1'b1; imem_rdata = 32'h5757_5757; tick(); imem_rvalid = 1'b0;
    vectors++;
    if (imem_req !== 1'b1 || imem_addr !== 64'h8000_5008 || valid_if_o !== 1'b0) begin
      miscompares++;
      $display("FAIL rgnt_refetch: req=%0b addr=%h valid=%0b, want 1/80005008/0", imem_req, imem_addr, valid_if_o);
    end
    imem_gnt = 1'b1; tick(); imem_gnt = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'h0055_0093; tick(); imem_rvalid = 1'b0;
    vectors++;
    if (valid_if_o !== 1'b1 || pc_if_o !== 64'h8000_5008 || instr_if_o !== 32'h0055_0093) begin
      miscompares++;
      $display("FAIL rgnt_final: valid=%0b pc=%h instr=%h, want 1/80005008/00550093", valid_if_o, pc_if_o, instr_if_o);
    end
    tick();
  endtask

  task automatic test_rst_mid();
    imem_gnt = 1'b1; tick(); imem_gnt = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if (valid_if_o !== 1'b0 || pc_if_o !== 64'h0 || instr_if_o !== 32'h0 ||
        imem_req !== 1'b1 || imem_addr !== 64'h8000_0000) begin
      miscompares++;
      $display("FAIL rst_mid: valid=%0b pc=%h instr=%h req=%0b addr=%h, want 0/0/0/1/80000000",
               valid_if_o, pc_if_o, instr_if_o, imem_req, imem_addr);
    end
    imem_rvalid = 1'b1; imem_rdata = 32'hBADB_AD00; tick(); imem_rvalid = 1'b0;
    vectors++;
    if (valid_if_o !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 64'h8000_0000) begin
      miscompares++;
      $display("FAIL rst_stale: valid=%0b req=%0b addr=%h, want 0/1/80000000", valid_if_o, imem_req, imem_addr);
    end
    imem_gnt = 1'b1; tick(); imem_gnt = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'h0000_0297; tick(); imem_rvalid = 1'b0;
    vectors++;
    if (valid_if_o !== 1'b1 || pc_if_o !== 64'h8000_0000 || instr_if_o !== 32'h0000_0297) begin
      miscompares++;
      $display("FAIL rst_refetch: valid=%0b pc=%h instr=%h, want 1/80000000/00000297", valid_if_o, pc_if_o, instr_if_o);
    end
  endtask

  task automatic test_wrap();
    redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    redirect_valid = 1'b0;
    vectors++;
    if (imem_addr !== 64'hFFFF_FFFF_FFFF_FFFC || valid_if_o !== 1'b0) begin
      miscompares++;
      $display("FAIL wrap_target: addr=%h valid=%0b, want fffffffffffffffc/0", imem_addr, valid_if_o);
    end
    imem_gnt = 1'b1; tick(); imem_gnt = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'h7777_0001; tick(); imem_rvalid = 1'b0;
    vectors++;
    if (pc_if_o !== 64'hFFFF_FFFF_FFFF_FFFC || instr_if_o !== 32'h7777_0001 || imem_addr !== 64'h0) begin
      miscompares++;
      $display("FAIL wrap_next: pc=%h instr=%h addr=%h, want fffffffffffffffc/77770001/0", pc_if_o, instr_if_o, imem_addr);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_drop();
    test_redirect_wait_hold();
    test_redirect_req_gnt();
    test_rst_mid();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
